// File: rtl/xorshift_cpu.sv
// Per-instance xorshift64 word generator: emits TRANSACTION_NB pseudo-random words
// with 0..3 idle cycles between them, then parks in DONE until reset.
module xorshift_cpu #(
  parameter int CPU_INDEX      = 0,
  parameter int TRANSACTION_NB = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        data_vld,
  output logic [63:0] data,
  output logic        transactions_done
);

  localparam logic [31:0] IDX  = CPU_INDEX;
  localparam logic [31:0] NB   = TRANSACTION_NB;
  localparam logic [63:0] SEED = 64'h9E3779B97F4A7C15 ^ {32'd0, IDX};

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_t;

  function automatic logic [63:0] xs(input logic [63:0] v);
    logic [63:0] t;
    t = v ^ (v << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  state_t      r_state;
  logic [63:0] r_x;
  logic [1:0]  r_gap;
  logic [31:0] r_count;
  logic        r_data_vld;
  logic [63:0] r_data;
  logic        r_done;

  logic [63:0] w_next_x;

  assign w_next_x = xs(r_x);

  // Generator FSM: emit when the idle counter is empty, otherwise count it down.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_x        <= SEED;
      r_gap      <= 2'd0;
      r_count    <= 32'd0;
      r_data_vld <= 1'b0;
      r_data     <= 64'd0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (r_gap == 2'd0) begin
            r_x        <= w_next_x;
            r_data     <= w_next_x;
            r_data_vld <= 1'b1;
            r_count    <= r_count + 32'd1;
            // Low bits of the emitted word set the idle time before the next one.
            r_gap      <= w_next_x[1:0];
            if (r_count + 32'd1 == NB) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_done  <= 1'b0;
            end
          end else begin
            r_data_vld <= 1'b0;
            r_gap      <= r_gap - 2'd1;
          end
        end
        DONE: begin
          r_data_vld <= 1'b0;
          r_done     <= 1'b1;
        end
        default: begin
          r_state    <= RUN;
          r_data_vld <= 1'b0;
        end
      endcase
    end
  end

  assign data_vld          = r_data_vld;
  assign data              = r_data;
  assign transactions_done = r_done;

endmodule

// File: tb/tb_xorshift_cpu.sv
// Self-checking bench for xorshift_cpu: five instances compared each cycle
// against a pulse-timeline reference model, plus directed boundary checks.
module tb_xorshift_cpu;

  localparam logic [63:0] GOLD = 64'h9E3779B97F4A7C15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0;
  logic        rst_m;
  logic [4:0]  vld_w;
  logic [4:0]  done_w;
  logic [63:0] data_w [5];

  int n_assert = 0;
  int n_fail   = 0;

  int idx_tab[5] = '{0, 1, 2, 3, 5};
  int nb_tab[5]  = '{16, 16, 16, 16, 1};

  logic [63:0] m_x    [5];
  logic [63:0] m_data [5];
  int          m_cnt  [5];
  int          m_cyc  [5];
  int          m_next [5];
  int          pcnt   [5];
  logic [63:0] first_w[5];
  bit          got_first[5];

  int          gap_cnt;
  bit          have_prev;
  logic [63:0] prev_data;

  xorshift_cpu #(.CPU_INDEX(0), .TRANSACTION_NB(16)) u0 (
    .clk(clk), .rst(rst0), .data_vld(vld_w[0]), .data(data_w[0]), .transactions_done(done_w[0]));
  xorshift_cpu #(.CPU_INDEX(1), .TRANSACTION_NB(16)) u1 (
    .clk(clk), .rst(rst_m), .data_vld(vld_w[1]), .data(data_w[1]), .transactions_done(done_w[1]));
  xorshift_cpu #(.CPU_INDEX(2), .TRANSACTION_NB(16)) u2 (
    .clk(clk), .rst(rst_m), .data_vld(vld_w[2]), .data(data_w[2]), .transactions_done(done_w[2]));
  xorshift_cpu #(.CPU_INDEX(3), .TRANSACTION_NB(16)) u3 (
    .clk(clk), .rst(rst_m), .data_vld(vld_w[3]), .data(data_w[3]), .transactions_done(done_w[3]));
  xorshift_cpu #(.CPU_INDEX(5), .TRANSACTION_NB(1)) u4 (
    .clk(clk), .rst(rst_m), .data_vld(vld_w[4]), .data(data_w[4]), .transactions_done(done_w[4]));

  function automatic logic [63:0] xs(input logic [63:0] v);
    logic [63:0] t;
    t = v ^ (v << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int i);
    m_x[i]       = GOLD ^ {32'd0, 32'(idx_tab[i])};
    m_data[i]    = 64'd0;
    m_cnt[i]     = 0;
    m_cyc[i]     = 0;
    m_next[i]    = 1;
    pcnt[i]      = 0;
    got_first[i] = 1'b0;
    if (i == 0) begin
      have_prev = 1'b0;
      gap_cnt   = 0;
    end
  endtask

  // One clock: advance the timeline model of every instance and compare outputs.
  task automatic tick();
    bit r;
    bit ev;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      r  = (i == 0) ? rst0 : rst_m;
      ev = 1'b0;
      if (r) begin
        model_reset(i);
      end else begin
        m_cyc[i]++;
        ev = (m_cnt[i] < nb_tab[i]) && (m_cyc[i] == m_next[i]);
        if (ev) begin
          m_x[i]    = xs(m_x[i]);
          m_data[i] = m_x[i];
          m_cnt[i]++;
          m_next[i] = m_cyc[i] + 1 + int'(m_x[i][1:0]);
        end
      end
      chk($sformatf("vld%0d", i), {63'd0, vld_w[i]}, {63'd0, ev});
      chk($sformatf("data%0d", i), data_w[i], m_data[i]);
      chk($sformatf("done%0d", i), {63'd0, done_w[i]}, {63'd0, (m_cnt[i] == nb_tab[i])});
      if (!r && vld_w[i]) begin
        pcnt[i]++;
        if (!got_first[i]) begin
          first_w[i]   = data_w[i];
          got_first[i] = 1'b1;
        end
      end
    end
    if (!rst0) begin
      if (vld_w[0]) begin
        if (have_prev) chk("gap0", 64'(gap_cnt), {62'd0, prev_data[1:0]});
        prev_data = data_w[0];
        gap_cnt   = 0;
        have_prev = 1'b1;
      end else if (have_prev) begin
        gap_cnt++;
      end
    end
  endtask

  initial begin
    int k;
    for (int i = 0; i < 5; i++) model_reset(i);
    rst0  = 1'b1;
    rst_m = 1'b1;
    tick();
    tick();
    chk("rst_vld", {63'd0, vld_w[0]}, 64'd0);
    chk("rst_data", data_w[0], 64'd0);
    chk("rst_done", {63'd0, done_w[0]}, 64'd0);

    // Free run from release: first word one cycle later, then the full sequence.
    rst0  = 1'b0;
    rst_m = 1'b0;
    tick();
    chk("first_vld", {63'd0, vld_w[0]}, 64'd1);
    chk("first_data", data_w[0], xs(GOLD));
    chk("one_done_first", {63'd0, done_w[4]}, 64'd1);
    repeat (199) tick();
    chk("pulses0", 64'(pcnt[0]), 64'd16);
    chk("pulses_one", 64'(pcnt[4]), 64'd1);
    for (int i = 0; i < 5; i++) chk($sformatf("final_done%0d", i), {63'd0, done_w[i]}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      for (int j = i + 1; j < 4; j++) begin
        n_assert++;
        assert (first_w[i] !== first_w[j]) else begin
          n_fail++;
          $error("FAIL distinct%0d%0d observed=%h expected_not=%h", i, j, first_w[i], first_w[j]);
        end
      end
    end

    // Restart all, then reset instance 0 for one cycle right after its fifth pulse.
    rst0  = 1'b1;
    rst_m = 1'b1;
    repeat (2 + int'($urandom_range(0, 3))) tick();
    rst0  = 1'b0;
    rst_m = 1'b0;
    k = 0;
    while (k < 100 && pcnt[0] < 5) begin
      tick();
      k++;
    end
    chk("reach5", 64'(pcnt[0]), 64'd5);
    rst0 = 1'b1;
    tick();
    chk("mid_rst_vld", {63'd0, vld_w[0]}, 64'd0);
    chk("mid_rst_data", data_w[0], 64'd0);
    chk("mid_rst_done", {63'd0, done_w[0]}, 64'd0);
    rst0 = 1'b0;
    tick();
    chk("restart_vld", {63'd0, vld_w[0]}, 64'd1);
    chk("restart_data", data_w[0], xs(GOLD));
    repeat (150 + int'($urandom_range(0, 20))) tick();
    chk("restart_pulses0", 64'(pcnt[0]), 64'd16);
    chk("restart_done0", {63'd0, done_w[0]}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/xorshift_cpu.md
XORSHIFT_CPU -- requirements
Module: xorshift_cpu

Interface
REQ-001 SHALL have parameter CPU_INDEX, default 0, int in 0..2^31-1, per-instance index that selects the seed.
REQ-002 SHALL have parameter TRANSACTION_NB, default 16, int >= 1, number of words emitted before completion.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port data_vld, output, 1 bit, high for exactly one cycle per emitted word.
REQ-006 SHALL have port data, output, 64 bits, emitted word; meaningful only when data_vld=1.
REQ-007 SHALL have port transactions_done, output, 1 bit, sticky high once TRANSACTION_NB words are emitted.
REQ-008 SHALL register all outputs (no combinational path from any input to any output).

Function
REQ-009 SHALL hold internal state: x (64b PRNG state), gap (2b idle counter), count (32b words emitted), fsm in {RUN, DONE}.
REQ-010 SHALL define SEED = 64'h9E3779B97F4A7C15 XOR zero-extended CPU_INDEX, which is nonzero for every legal CPU_INDEX.
REQ-011 SHALL define xs(v) as the xorshift64 sequence: t=v^(v<<13); t=t^(t>>7); t=t^(t<<17); all shifts logical, 64-bit, truncating.
REQ-012 In RUN with gap==0, SHALL: x<=xs(x); data<=xs(x); data_vld<=1; count<=count+1; gap<=xs(x)[1:0].
REQ-013 In RUN with gap!=0, SHALL: data_vld<=0; gap<=gap-1; x, data, count unchanged.
REQ-014 SHALL leave 0..3 idle cycles between consecutive data_vld pulses, the number equal to bits [1:0] of the word just emitted.
REQ-015 When the emission in REQ-012 makes count equal to TRANSACTION_NB, SHALL move fsm to DONE on that same edge.
REQ-016 SHALL assert transactions_done on the edge where fsm enters DONE, coincident with the final data_vld pulse.
REQ-017 In DONE, SHALL drive data_vld=0, keep transactions_done=1, and hold data and x at their final values until rst.
REQ-018 SHALL emit exactly TRANSACTION_NB pulses between reset release and DONE.
REQ-019 SHALL give the emitted sequence as xs(SEED), xs(xs(SEED)), and so on, independent of the idle gaps.
REQ-020 SHALL never produce x==0, which the nonzero seed and xorshift's bijectivity guarantee.

Reset
REQ-021 On any rising clk with rst=1, SHALL set x=SEED, gap=0, count=0, fsm=RUN, data_vld=0, data=0, transactions_done=0.
REQ-022 SHALL have rst take priority over all other updates, including mid-run and in DONE, after which the sequence restarts from SEED.
REQ-023 SHALL emit the first word (data_vld=1) on the first rising edge with rst=0, so it is visible in the following cycle.

Verification
REQ-024 Bench SHALL cover: CPU_INDEX=0, rst 2 cycles then low -> first data equals xs(64'h9E3779B97F4A7C15), valid 1 cycle after release.
REQ-025 Bench SHALL cover: TRANSACTION_NB=16, free run -> exactly 16 data_vld pulses, words matching the reference model in order, transactions_done rising with pulse 16 and staying 1 for 100+ cycles.
REQ-026 Bench SHALL cover gap check -> idle cycles after each pulse equal data[1:0] of that pulse (0..3); no pulse is ever longer than 1 cycle.
REQ-027 Bench SHALL cover: four instances with CPU_INDEX 0..3 -> first words pairwise distinct; all four done flags eventually 1.
REQ-028 Bench SHALL cover: rst asserted after pulse 5, held 1 cycle -> outputs 0 next cycle, then sequence restarts at xs(SEED) with count from 0.
REQ-029 Bench SHALL cover: TRANSACTION_NB=1 -> a single pulse with transactions_done=1 on the same edge and no further pulses.
